// File: rtl/turf_event_readout_sched.sv
// turf_event_readout_sched
// Assembles one readout event per trigger: HDR_QWORDS header qwords from the
// header stream, followed by TIO_QWORDS qwords from each unmasked TURFIO
// source in ascending index order. Routing is combinational, so it adds no
// latency. The FSM only decides which stream currently owns m_ev.
//
// Optional feature: define READOUT_STATS_EN to build the event and stall
// counters. Without it, ev_count_o and stall_count_o are tied to zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for enable_i && s_thdr_tvalid; the mask is latched here
// HEADER   | header stream routed to m_ev
// TIO_SEL  | one bubble cycle that picks the next unmasked source, if any
// TIO_DATA | selected TURFIO source routed to m_ev
// DONE     | one cycle; event_done_o pulses

module turf_event_readout_sched #(
    parameter int NUM_TIO    = 4,
    parameter int HDR_QWORDS = 16,
    parameter int TIO_QWORDS = 64
) (
    input  logic                  memclk,
    input  logic                  memresetn,
    input  logic                  enable_i,
    input  logic [NUM_TIO-1:0]    tio_mask_i,
    input  logic [63:0]           s_thdr_tdata,
    input  logic                  s_thdr_tvalid,
    output logic                  s_thdr_tready,
    input  logic [64*NUM_TIO-1:0] s_tio_tdata,
    input  logic [NUM_TIO-1:0]    s_tio_tvalid,
    output logic [NUM_TIO-1:0]    s_tio_tready,
    output logic [63:0]           m_ev_tdata,
    output logic                  m_ev_tvalid,
    input  logic                  m_ev_tready,
    output logic                  m_ev_tlast,
    output logic                  event_done_o,
    output logic                  busy_o,
    output logic [31:0]           ev_count_o,
    output logic [31:0]           stall_count_o
);

    localparam int MAXQ  = (HDR_QWORDS > TIO_QWORDS) ? HDR_QWORDS : TIO_QWORDS;
    localparam int CNT_W = $clog2(MAXQ + 1);
    // The index must be able to hold NUM_TIO, which means "no sources left to search".
    localparam int IDX_W = $clog2(NUM_TIO + 1);
    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_QWORDS - 1);
    localparam logic [CNT_W-1:0] TIO_LAST = CNT_W'(TIO_QWORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_TIO_SEL,
        ST_TIO_DATA,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   qcnt_q, qcnt_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   next_idx_q, next_idx_d;
    logic [NUM_TIO-1:0] mask_q, mask_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [63:0]        sel_tdata;
    logic               sel_tvalid;
    logic               last_src;
    logic               found;
    logic [IDX_W-1:0]   found_idx;
    logic               xfer;

    // Stream routing: the owner of m_ev is chosen purely by the current state.
    always_comb begin
        sel_tdata     = '0;
        sel_tvalid    = 1'b0;
        last_src      = 1'b1;
        m_ev_tdata    = '0;
        m_ev_tvalid   = 1'b0;
        m_ev_tlast    = 1'b0;
        s_thdr_tready = 1'b0;
        s_tio_tready  = '0;
        for (int i = 0; i < NUM_TIO; i++) begin
            if (sel_q == IDX_W'(i)) begin
                sel_tdata  = s_tio_tdata[64*i +: 64];
                sel_tvalid = s_tio_tvalid[i];
            end
            if ((IDX_W'(i) > sel_q) && !mask_q[i]) begin
                last_src = 1'b0;
            end
        end
        case (state_q)
            ST_HEADER: begin
                m_ev_tdata    = s_thdr_tdata;
                m_ev_tvalid   = s_thdr_tvalid;
                s_thdr_tready = m_ev_tready;
                m_ev_tlast    = (qcnt_q == HDR_LAST) && (&mask_q);
            end
            ST_TIO_DATA: begin
                m_ev_tdata  = sel_tdata;
                m_ev_tvalid = sel_tvalid;
                m_ev_tlast  = (qcnt_q == TIO_LAST) && last_src;
                for (int i = 0; i < NUM_TIO; i++) begin
                    s_tio_tready[i] = (sel_q == IDX_W'(i)) && m_ev_tready;
                end
            end
            default: begin
            end
        endcase
    end

    assign xfer = m_ev_tvalid && m_ev_tready;

    // Next-state, counter and source-selection logic.
    always_comb begin
        state_d    = state_q;
        qcnt_d     = qcnt_q;
        sel_d      = sel_q;
        next_idx_d = next_idx_q;
        mask_d     = mask_q;
        found      = 1'b0;
        found_idx  = '0;
        // Scan downwards so that the lowest eligible index is the one kept.
        for (int i = NUM_TIO - 1; i >= 0; i--) begin
            if ((IDX_W'(i) >= next_idx_q) && !mask_q[i]) begin
                found     = 1'b1;
                found_idx = IDX_W'(i);
            end
        end
        case (state_q)
            ST_IDLE: begin
                if (enable_i && s_thdr_tvalid) begin
                    state_d    = ST_HEADER;
                    mask_d     = tio_mask_i;
                    qcnt_d     = '0;
                    sel_d      = '0;
                    next_idx_d = '0;
                end
            end
            ST_HEADER: begin
                if (xfer) begin
                    if (qcnt_q == HDR_LAST) begin
                        qcnt_d  = '0;
                        state_d = ST_TIO_SEL;
                    end else begin
                        qcnt_d = qcnt_q + CNT_W'(1);
                    end
                end
            end
            ST_TIO_SEL: begin
                if (found) begin
                    sel_d      = found_idx;
                    next_idx_d = found_idx + IDX_W'(1);
                    qcnt_d     = '0;
                    state_d    = ST_TIO_DATA;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_TIO_DATA: begin
                if (xfer) begin
                    if (qcnt_q == TIO_LAST) begin
                        qcnt_d  = '0;
                        state_d = ST_TIO_SEL;
                    end else begin
                        qcnt_d = qcnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // FSM register, including the registered status outputs.
    always_ff @(posedge memclk or negedge memresetn) begin
        if (!memresetn) begin
            state_q    <= ST_IDLE;
            qcnt_q     <= '0;
            sel_q      <= '0;
            next_idx_q <= '0;
            mask_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            qcnt_q     <= qcnt_d;
            sel_q      <= sel_d;
            next_idx_q <= next_idx_d;
            mask_q     <= mask_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy_o       = busy_q;
    assign event_done_o = done_q;

`ifdef READOUT_STATS_EN
    logic [31:0] ev_count_q, ev_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // The event count wraps naturally; the stall count sticks at all-ones.
    always_comb begin
        ev_count_d    = ev_count_q;
        stall_count_d = stall_count_q;
        if (state_q == ST_DONE) begin
            ev_count_d = ev_count_q + 32'd1;
        end
        if ((state_q != ST_IDLE) && m_ev_tvalid && !m_ev_tready &&
            (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge memclk or negedge memresetn) begin
        if (!memresetn) begin
            ev_count_q    <= '0;
            stall_count_q <= '0;
        end else begin
            ev_count_q    <= ev_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign ev_count_o    = ev_count_q;
    assign stall_count_o = stall_count_q;
`else
    assign ev_count_o    = '0;
    assign stall_count_o = '0;
`endif

endmodule
